// File: rtl/pad_share_pkg.sv
// rtl/pad_share_pkg.sv - shared types and limits for the pad share arbiter
package pad_share_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TURN = 2'd1,
      ST_OWN  = 2'd2
   } state_e;

   // Legal parameter limits
   localparam int MAX_REQ  = 8;
   localparam int MAX_TURN = 15;

endpackage

// File: rtl/pad_share_rr_pick.sv
// rtl/pad_share_rr_pick.sv - round-robin first-set search starting after the pointer
module pad_share_rr_pick
   import pad_share_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic          valid_o,
   output logic [IW-1:0] idx_o
);

   int j;

   // Scan ptr+1 .. ptr+N (mod N); the pointer's own bit is visited last
   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      j       = 0;
      for (int off = 1; off <= N; off++) begin
         j = (int'(ptr_i) + off) % N;
         if (!valid_o && req_i[j]) begin
            valid_o = 1'b1;
            idx_o   = j[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/pad_share_arbiter.sv
// rtl/pad_share_arbiter.sv - round-robin owner arbitration of one shared bidirectional pad
module pad_share_arbiter
   import pad_share_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int TURN_CYCLES = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [NUM_REQ-1:0] oe_i,
   input  logic [NUM_REQ-1:0] data_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic               data_o,
   output logic               busy_o,
   output logic               pad_oen_o,
   output logic               pad_out_o,
   input  logic               pad_in_i
);

   localparam int IW = $clog2(NUM_REQ);

   // Reject out-of-range configurations at elaboration
   if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_bad_num_req
      $error("pad_share_arbiter: NUM_REQ out of range");
   end
   if (TURN_CYCLES < 1 || TURN_CYCLES > MAX_TURN) begin : g_bad_turn
      $error("pad_share_arbiter: TURN_CYCLES out of range");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
      $error("pad_share_arbiter: SYNC_STAGES out of range");
   end

   state_e               state_q;
   logic [IW-1:0]        owner_q;
   logic [IW-1:0]        ptr_q;
   logic [3:0]           cnt_q;
   logic [NUM_REQ-1:0]   gnt_q;
   logic                 pad_oen_q;
   logic                 pad_out_q;
   logic                 busy_q;
   logic [SYNC_STAGES-1:0] sync_q;

   logic                 pick_valid;
   logic [IW-1:0]        pick_idx;

   // ptr_q equals the current owner while in OWN, so the owner is searched last
   pad_share_rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_pick (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   // Pad input synchronizer, free-running in every state
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in_i};
      end
   end

   // Ownership FSM with registered grant, pad controls and busy flag
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         owner_q   <= '0;
         ptr_q     <= IW'(NUM_REQ - 1);
         cnt_q     <= '0;
         gnt_q     <= '0;
         pad_oen_q <= 1'b1;
         pad_out_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               gnt_q     <= '0;
               pad_oen_q <= 1'b1;
               pad_out_q <= 1'b0;
               if (pick_valid) begin
                  state_q <= ST_TURN;
                  owner_q <= pick_idx;
                  cnt_q   <= 4'(TURN_CYCLES);
                  busy_q  <= 1'b1;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            ST_TURN: begin
               pad_oen_q <= 1'b1;
               pad_out_q <= 1'b0;
               if (!req_i[owner_q]) begin
                  // Candidate withdrew before owning: give up, pointer untouched
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
                  gnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (cnt_q == 4'd1) begin
                  state_q <= ST_OWN;
                  cnt_q   <= '0;
                  gnt_q   <= NUM_REQ'(1) << owner_q;
                  ptr_q   <= owner_q;
                  busy_q  <= 1'b1;
               end else begin
                  cnt_q   <= cnt_q - 4'd1;
                  busy_q  <= 1'b1;
               end
            end
            ST_OWN: begin
               if (!req_i[owner_q]) begin
                  // Release: stop driving on this very edge, then re-arbitrate
                  gnt_q     <= '0;
                  pad_oen_q <= 1'b1;
                  pad_out_q <= 1'b0;
                  if (pick_valid) begin
                     state_q <= ST_TURN;
                     owner_q <= pick_idx;
                     cnt_q   <= 4'(TURN_CYCLES);
                     busy_q  <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  pad_oen_q <= ~oe_i[owner_q];
                  pad_out_q <= data_i[owner_q];
                  busy_q    <= 1'b1;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               gnt_q     <= '0;
               pad_oen_q <= 1'b1;
               pad_out_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign gnt_o     = gnt_q;
   assign pad_oen_o = pad_oen_q;
   assign pad_out_o = pad_out_q;
   assign busy_o    = busy_q;
   assign data_o    = sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_pad_share_arbiter.sv
// tb/tb_pad_share_arbiter.sv - directed self-checking bench for pad_share_arbiter
module tb_pad_share_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req;
   logic [1:0] oe;
   logic [1:0] din;
   logic [1:0] gnt;
   logic       dout;
   logic       busy;
   logic       oen;
   logic       pout;
   logic       pin;

   int n_cmp  = 0;
   int n_fail = 0;

   pad_share_arbiter #(
      .NUM_REQ     (2),
      .TURN_CYCLES (2),
      .SYNC_STAGES (2)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .req_i     (req),
      .oe_i      (oe),
      .data_i    (din),
      .gnt_o     (gnt),
      .data_o    (dout),
      .busy_o    (busy),
      .pad_oen_o (oen),
      .pad_out_o (pout),
      .pad_in_i  (pin)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 2'b00;
      oe    = 2'b00;
      din   = 2'b00;
      pin   = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 2'b11;
      oe    = 2'b11;
      din   = 2'b11;
      pin   = 1'b1;
      #13;
      n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", gnt); end
      n_cmp++; if (oen !== 1'b1) begin n_fail++; $display("FAIL reset_oen: got %b want 1", oen); end
      n_cmp++; if (pout !== 1'b0) begin n_fail++; $display("FAIL reset_pout: got %b want 0", pout); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout: got %b want 0", dout); end
   endtask

   task automatic test_single();
      do_reset();
      req = 2'b01; oe = 2'b01; din = 2'b01;
      step(); // edge 1
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_e1: got %b want 1", busy); end
      n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL single_gnt_e1: got %b want 00", gnt); end
      step(); // edge 2
      n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL single_gnt_e2: got %b want 00", gnt); end
      step(); // edge 3
      n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt_e3: got %b want 01", gnt); end
      n_cmp++; if (oen !== 1'b1) begin n_fail++; $display("FAIL single_oen_e3: got %b want 1", oen); end
      step(); // edge 4
      n_cmp++; if (oen !== 1'b0) begin n_fail++; $display("FAIL single_oen_e4: got %b want 0", oen); end
      n_cmp++; if (pout !== 1'b1) begin n_fail++; $display("FAIL single_pout_e4: got %b want 1", pout); end
      req = 2'b00;
      step(); // edge 5: release with nobody waiting
      n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL single_rel_gnt: got %b want 00", gnt); end
      n_cmp++; if (oen !== 1'b1) begin n_fail++; $display("FAIL single_rel_oen: got %b want 1", oen); end
      n_cmp++; if (pout !== 1'b0) begin n_fail++; $display("FAIL single_rel_pout: got %b want 0", pout); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_rel_busy: got %b want 0", busy); end
      // Pointer now at 0, so a simultaneous request favours requester 1
      req = 2'b11;
      step(); step();
      n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL single_ptr_gnt_e7: got %b want 00", gnt); end
      step();
      n_cmp++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL single_ptr_gnt_e8: got %b want 10", gnt); end
      req = 2'b00;
   endtask

   task automatic test_handover();
      do_reset();
      req = 2'b11; oe = 2'b11; din = 2'b01;
      step(); step(); step(); // edge 3
      n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL hand_first_gnt: got %b want 01", gnt); end
      step(); // edge 4
      n_cmp++; if (pout !== 1'b1) begin n_fail++; $display("FAIL hand_pout_e4: got %b want 1", pout); end
      n_cmp++; if (oen !== 1'b0) begin n_fail++; $display("FAIL hand_oen_e4: got %b want 0", oen); end
      step(); // edge 5: non-owner drive still ignored
      n_cmp++; if (pout !== 1'b1) begin n_fail++; $display("FAIL hand_pout_e5: got %b want 1", pout); end
      req = 2'b10;
      step(); // edge 6
      n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL hand_gnt_e6: got %b want 00", gnt); end
      n_cmp++; if (oen !== 1'b1) begin n_fail++; $display("FAIL hand_oen_e6: got %b want 1", oen); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hand_busy_e6: got %b want 1", busy); end
      step(); // edge 7
      n_cmp++; if (oen !== 1'b1) begin n_fail++; $display("FAIL hand_oen_e7: got %b want 1", oen); end
      n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL hand_gnt_e7: got %b want 00", gnt); end
      step(); // edge 8
      n_cmp++; if (oen !== 1'b1) begin n_fail++; $display("FAIL hand_oen_e8: got %b want 1", oen); end
      n_cmp++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL hand_gnt_e8: got %b want 10", gnt); end
      step(); // edge 9: new owner drives its own 0
      n_cmp++; if (oen !== 1'b0) begin n_fail++; $display("FAIL hand_oen_e9: got %b want 0", oen); end
      n_cmp++; if (pout !== 1'b0) begin n_fail++; $display("FAIL hand_pout_e9: got %b want 0", pout); end
      req = 2'b00;
      step();
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hand_busy_end: got %b want 0", busy); end
   endtask

   task automatic test_abort();
      do_reset();
      req = 2'b01;
      step(); // edge 1: TURN
      req = 2'b00;
      step(); // edge 2: abort
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
      n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL abort_gnt: got %b want 00", gnt); end
      // Pointer must still be 1, so requester 0 wins the tie
      req = 2'b11;
      step(); step();
      n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL abort_gnt_turn: got %b want 00", gnt); end
      step();
      n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL abort_ptr_gnt: got %b want 01", gnt); end
      req = 2'b00;
   endtask

   task automatic test_reset_mid_own();
      do_reset();
      req = 2'b01; oe = 2'b01; din = 2'b01;
      step(); step(); step(); step(); // driving now
      n_cmp++; if (oen !== 1'b0) begin n_fail++; $display("FAIL arst_pre_oen: got %b want 0", oen); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (oen !== 1'b1) begin n_fail++; $display("FAIL arst_oen: got %b want 1", oen); end
      n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL arst_gnt: got %b want 00", gnt); end
      n_cmp++; if (pout !== 1'b0) begin n_fail++; $display("FAIL arst_pout: got %b want 0", pout); end
      @(negedge clk);
      rst_n = 1'b1;
      req = 2'b00;
   endtask

   task automatic test_sync();
      do_reset();
      pin = 1'b1; // rise in IDLE
      step();
      n_cmp++; if (dout !== 1'b0) begin n_fail++; $display("FAIL sync_idle_e1: got %b want 0", dout); end
      step();
      n_cmp++; if (dout !== 1'b1) begin n_fail++; $display("FAIL sync_idle_e2: got %b want 1", dout); end
      pin = 1'b0;
      step(); step();
      n_cmp++; if (dout !== 1'b0) begin n_fail++; $display("FAIL sync_fall: got %b want 0", dout); end
      req = 2'b01; oe = 2'b01; din = 2'b01;
      step(); // TURN
      pin = 1'b1; // rise in TURN
      step();
      n_cmp++; if (dout !== 1'b0) begin n_fail++; $display("FAIL sync_turn_e1: got %b want 0", dout); end
      step();
      n_cmp++; if (dout !== 1'b1) begin n_fail++; $display("FAIL sync_turn_e2: got %b want 1", dout); end
      n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL sync_own_gnt: got %b want 01", gnt); end
      pin = 1'b0;
      step(); step();
      n_cmp++; if (dout !== 1'b0) begin n_fail++; $display("FAIL sync_fall2: got %b want 0", dout); end
      pin = 1'b1; // rise in OWN
      step();
      n_cmp++; if (dout !== 1'b0) begin n_fail++; $display("FAIL sync_own_e1: got %b want 0", dout); end
      step();
      n_cmp++; if (dout !== 1'b1) begin n_fail++; $display("FAIL sync_own_e2: got %b want 1", dout); end
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sync_own_busy: got %b want 1", busy); end
      req = 2'b00;
      pin = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_handover();
      test_abort();
      test_reset_mid_own();
      test_sync();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
